mips32_hazard_scoreboard: RTL and testbench
===========================================

// Module: mips32_hazard_scoreboard
// PURPOSE
//  Parametrised RAW-hazard scoreboard for the pipe_MIPS32 core. Sits beside the ID stage.
//  Tracks destination registers of in-flight instructions and stalls issue on a pending source,
//  so programs no longer need dummy instructions between dependent ops. Also tracks HLT.
// PARAMETERS
//  NREG        32  architectural registers; R0 is hardwired zero
//  RADDR_W      5  register address width, must equal clog2(NREG)
//  PIPE_DEPTH   3  ID-issue to regfile-write distance in clk1 cycles (>=2)
// PORTS
//  clk1        in   1          single clock, all state on rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  id_valid    in   1          instruction present in ID requesting issue
//  id_rs       in   RADDR_W    source A register
//  id_rt       in   RADDR_W    source B register
//  id_rs_used  in   1          source A is read
//  id_rt_used  in   1          source B is read
//  id_rd       in   RADDR_W    destination register
//  id_wr_en    in   1          instruction writes id_rd
//  id_is_load  in   1          instruction is LW (result late)
//  id_halt     in   1          instruction is HLT
//  flush       in   1          TAKEN_BRANCH: squash the ID instruction this cycle
//  stall       out  1          hold IF/ID; combinational
//  issue       out  1          ID instruction advances this cycle; combinational
//  halted      out  1          HLT has issued; registered, sticky
//  busy        out  NREG       bitmap of registers with pending write
//  fwd_a       out  2          forward select for source A (0 = regfile)
//  fwd_b       out  2          forward select for source B (0 = regfile)
// BEHAVIOUR
//  - State: shadow pipe ent[0..PIPE_DEPTH-1] of {valid, rd, is_load}; halted flag.
//  - Reset (async, rst_n=0): all ent.valid=0, halted=0 -> stall=0, issue=0, busy=0, fwd=0.
//  - Every clk1 edge: ent[i+1]<=ent[i]; ent[0]<=issue&id_wr_en&(id_rd!=0) ? {1,id_rd,id_is_load} : bubble.
//  - ent[PIPE_DEPTH-1] is writing back this cycle; regfile is write-before-read, so it never hazards.
//  - Source match: used & reg!=0 & ent[i].valid & ent[i].rd==reg, i in 0..PIPE_DEPTH-2.
//  - stall = id_valid & !halted & !flush & (any source match).
//  - issue = id_valid & !halted & !flush & !stall.
//  - halted <= 1 on issue & id_halt; cleared only by reset. Shadow pipe keeps draining after halt.
//  - flush & stall same cycle: flush wins (stall=0, issue=0); in-flight entries are older, kept.
//  - Same rd in several entries: youngest (lowest i) governs match and forwarding.
//  - busy[r] = OR over all i of ent[i].valid & ent[i].rd==r; busy[0] always 0.
//  - Dependent op right after producer: PIPE_DEPTH-1 stall cycles (2 at default).
// CONFIGURATION
//  - MIPS32_SCB_FWD_EN defined: datapath has EX/MEM bypass. A match stalls only if youngest
//    matching entry is ent[0] with is_load (load-use, 1 cycle). Else fwd_x = youngest match i+1.
//  - Undefined: full stall on any match per above; fwd_a/fwd_b tied to 0.
// STRUCTURE
//  - mips32_pkg: RADDR_W default, opcode constants (ADDI, LW, HLT...), typedef scb_entry_t.
//  - Sub-module mips32_scb_match: per-source comparator + youngest-first priority encoder,
//    instanced once for rs, once for rt; returns hit, hit_idx, hit_is_load.
// TESTING
//  - Reset mid-stall: assert rst_n=0 while stall=1 -> stall, issue, busy, halted all 0 at once.
//  - ADDI R1,R0,10 then ADD R4,R1,R2 back-to-back -> no FWD: stall=1 for 2 cycles, then issue;
//    FWD: no stall, fwd_a=1 on ADD.
//  - LW R5 then ADD R6,R5,R3 -> FWD: 1 stall cycle then fwd_a=2; no FWD: 2 stall cycles.
//  - ADDI R0,R0,5 then ADD R7,R0,R0 -> no stall, busy stays 0.
//  - Dependent ADD stalled, flush=1 -> stall=0, issue=0; producer entry still retires.
//  - HLT issued -> halted=1 next edge; later id_valid -> issue=0; busy drains to 0 in PIPE_DEPTH.

Source files
------------

// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the pipe_MIPS32 hazard scoreboard:
//   - default sizing (register count, register address width, shadow depth)
//   - pipe_MIPS32 opcode encodings
//   - scb_entry_t: one shadow-pipe slot {valid, rd, is_load}
// No ports (package).
// -----------------------------------------------------------------------------
package mips32_pkg;

  localparam int SCB_NREG       = 32;
  localparam int SCB_RADDR_W    = 5;
  localparam int SCB_PIPE_DEPTH = 3;

  // Storage width of rd inside an entry. Wide enough for any practical
  // RADDR_W; narrower addresses are zero-extended before comparison.
  localparam int SCB_RD_W = 8;

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  typedef struct packed {
    logic                valid;
    logic [SCB_RD_W-1:0] rd;
    logic                is_load;
  } scb_entry_t;

endpackage

// File: rtl/mips32_scb_match.sv
// -----------------------------------------------------------------------------
// mips32_scb_match
// Compares one ID source register against the hazard-visible shadow entries
// and reports the youngest (lowest index) matching entry.
// Ports:
//   src_i          source register address
//   used_i         source is actually read by the instruction
//   ent_i          shadow entries 0..NCHK-1 (entry 0 is youngest)
//   hit_o          some entry matches
//   hit_idx_o      index of youngest matching entry
//   hit_is_load_o  youngest matching entry is a load
// -----------------------------------------------------------------------------
module mips32_scb_match
  import mips32_pkg::*;
#(
  parameter int RADDR_W = SCB_RADDR_W,
  parameter int NCHK    = SCB_PIPE_DEPTH - 1,
  parameter int IDX_W   = 1
) (
  input  logic [RADDR_W-1:0]         src_i,
  input  logic                       used_i,
  input  scb_entry_t [NCHK-1:0]      ent_i,
  output logic                       hit_o,
  output logic [IDX_W-1:0]           hit_idx_o,
  output logic                       hit_is_load_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o         = 1'b0;
    hit_idx_o     = '0;
    hit_is_load_o = 1'b0;
    for (int i = NCHK - 1; i >= 0; i--) begin
      if (used_i && (src_i != '0) && ent_i[i].valid &&
          (ent_i[i].rd == SCB_RD_W'(src_i))) begin
        hit_o         = 1'b1;
        hit_idx_o     = IDX_W'(i);
        hit_is_load_o = ent_i[i].is_load;
      end
    end
  end

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// mips32_hazard_scoreboard
// RAW-hazard scoreboard beside the pipe_MIPS32 ID stage. A shadow pipe records
// the destination of each issued instruction until it writes back; an ID
// instruction reading a pending register is held. Also latches HLT.
// Build option: define MIPS32_SCB_FWD_EN when the datapath has EX/MEM bypass;
// then only load-use stalls and fwd_a/fwd_b select the bypass source.
// Ports:
//   clk1, rst_n            clock, asynchronous active-low reset
//   id_valid               instruction in ID requests issue
//   id_rs/id_rt            source registers, id_rs_used/id_rt_used qualify them
//   id_rd, id_wr_en        destination and its write enable
//   id_is_load, id_halt    instruction is LW / HLT
//   flush                  taken branch squashes the ID instruction
//   stall, issue           combinational hold / advance of ID
//   halted                 sticky, set once HLT issues
//   busy                   bitmap of registers with a pending write
//   fwd_a, fwd_b           bypass select per source (0 = regfile)
// -----------------------------------------------------------------------------
module mips32_hazard_scoreboard
  import mips32_pkg::*;
#(
  parameter int NREG       = SCB_NREG,
  parameter int RADDR_W    = SCB_RADDR_W,
  parameter int PIPE_DEPTH = SCB_PIPE_DEPTH
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_wr_en,
  input  logic               id_is_load,
  input  logic               id_halt,
  input  logic               flush,
  output logic               stall,
  output logic               issue,
  output logic               halted,
  output logic [NREG-1:0]    busy,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  // The oldest entry is writing back this cycle; the regfile writes before it
  // is read, so only the younger PIPE_DEPTH-1 entries can hazard.
  localparam int NCHK  = PIPE_DEPTH - 1;
  localparam int IDX_W = (NCHK > 1) ? $clog2(NCHK) : 1;

  scb_entry_t [PIPE_DEPTH-1:0] ent_q, ent_d;
  logic                        halted_q, halted_d;

  logic             a_hit, b_hit, a_ld, b_ld, a_stall, b_stall, can_go;
  logic [IDX_W-1:0] a_idx, b_idx;

  mips32_scb_match #(.RADDR_W(RADDR_W), .NCHK(NCHK), .IDX_W(IDX_W)) u_match_rs (
    .src_i         (id_rs),
    .used_i        (id_rs_used),
    .ent_i         (ent_q[NCHK-1:0]),
    .hit_o         (a_hit),
    .hit_idx_o     (a_idx),
    .hit_is_load_o (a_ld)
  );

  mips32_scb_match #(.RADDR_W(RADDR_W), .NCHK(NCHK), .IDX_W(IDX_W)) u_match_rt (
    .src_i         (id_rt),
    .used_i        (id_rt_used),
    .ent_i         (ent_q[NCHK-1:0]),
    .hit_o         (b_hit),
    .hit_idx_o     (b_idx),
    .hit_is_load_o (b_ld)
  );

`ifdef MIPS32_SCB_FWD_EN
  // With bypass, only a load still in entry 0 (data not yet read) must wait.
  assign a_stall = a_hit && (a_idx == '0) && a_ld;
  assign b_stall = b_hit && (b_idx == '0) && b_ld;
  assign fwd_a   = (a_hit && !a_stall) ? (2'(a_idx) + 2'd1) : 2'd0;
  assign fwd_b   = (b_hit && !b_stall) ? (2'(b_idx) + 2'd1) : 2'd0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{a_idx, b_idx, a_ld, b_ld};
  assign a_stall    = a_hit;
  assign b_stall    = b_hit;
  assign fwd_a      = 2'd0;
  assign fwd_b      = 2'd0;
`endif

  // rst_n gates the handshake so stall/issue read 0 for the whole reset.
  assign can_go = rst_n && id_valid && !halted_q && !flush;
  assign stall  = can_go && (a_stall || b_stall);
  assign issue  = can_go && !(a_stall || b_stall);
  assign halted = halted_q;

  always_comb begin
    ent_d[0] = '0;
    if (issue && id_wr_en && (id_rd != '0)) begin
      ent_d[0].valid   = 1'b1;
      ent_d[0].rd      = SCB_RD_W'(id_rd);
      ent_d[0].is_load = id_is_load;
    end
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      ent_d[i] = ent_q[i-1];
    end
    halted_d = halted_q || (issue && id_halt);
  end

  // Register 0 is never entered into the shadow pipe, so busy[0] stays 0.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (ent_q[i].valid && (ent_q[i].rd == SCB_RD_W'(r))) begin
          busy[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ent_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      ent_q    <= ent_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_mips32_hazard_scoreboard.sv
module tb_mips32_hazard_scoreboard;

`ifdef MIPS32_SCB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk1, rst_n;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_halt, flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall, issue, halted;
  logic [31:0] busy;
  logic [1:0]  fwd_a, fwd_b;

  mips32_hazard_scoreboard dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .id_halt    (id_halt),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .halted     (halted),
    .busy       (busy),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt;
    logic       rsu, rtu;
    logic [4:0] rd;
    logic       wr, ld, hlt, fl;
  } stim_t;

  typedef struct packed {
    logic        stall, issue;
    logic [1:0]  fa, fb;
    logic [31:0] busy;
    logic        halted;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  int    total = 0;
  int    bad   = 0;

  function automatic stim_t I(int v, int rs, int rt, int rsu, int rtu,
                              int rd, int wr, int ld, int hlt, int fl);
    stim_t s;
    s.v = v[0]; s.rs = 5'(rs); s.rt = 5'(rt); s.rsu = rsu[0]; s.rtu = rtu[0];
    s.rd = 5'(rd); s.wr = wr[0]; s.ld = ld[0]; s.hlt = hlt[0]; s.fl = fl[0];
    return s;
  endfunction

  function automatic exp_t E(int st, int is, int fa, int fb, int bz, int h);
    exp_t e;
    e.stall = st[0]; e.issue = is[0]; e.fa = 2'(fa); e.fb = 2'(fb);
    e.busy = 32'(bz); e.halted = h[0];
    return e;
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.v;   id_rs = s.rs;   id_rt = s.rt;
    id_rs_used = s.rsu; id_rt_used = s.rtu;
    id_rd = s.rd;     id_wr_en = s.wr; id_is_load = s.ld;
    id_halt = s.hlt;  flush = s.fl;
  endtask

  // Instruction encodings used by the scenarios
  stim_t IDLE, ADDI_R1, ADD_R4, LW_R5, ADD_R6, ADDI_R0, ADD_R7, LW_R1, ADD_R4_FL,
         ADDI_R9, HLT, ADD_R10;

  initial begin
    IDLE      = I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ADDI_R1   = I(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    ADD_R4    = I(1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
    ADD_R4_FL = I(1, 1, 2, 1, 1, 4, 1, 0, 0, 1);
    LW_R5     = I(1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
    ADD_R6    = I(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
    ADDI_R0   = I(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    ADD_R7    = I(1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
    LW_R1     = I(1, 0, 0, 1, 0, 1, 1, 1, 0, 0);
    ADDI_R9   = I(1, 0, 0, 1, 0, 9, 1, 0, 0, 0);
    HLT       = I(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    ADD_R10   = I(1, 1, 1, 1, 1, 10, 1, 0, 0, 0);
  end

  task automatic test_reset();
    exp_t got, e;
    rst_n = 1'b0;
    apply(ADD_R4);
    eq.push_back(E(0, 0, 0, 0, 0, 0));
    @(negedge clk1);
    e = eq.pop_front();
    got = {stall, issue, fwd_a, fwd_b, busy, halted};
    total++;
    if (got !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
    @(posedge clk1); #1;
    rst_n = 1'b1;
    apply(IDLE);
    eq.push_back(E(0, 0, 0, 0, 0, 0));
    @(negedge clk1);
    e = eq.pop_front();
    got = {stall, issue, fwd_a, fwd_b, busy, halted};
    total++;
    if (got !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, e); end
  endtask

  task automatic test_raw_alu();
    stim_t s; exp_t got, e; int n = 0;
    sq.push_back(ADDI_R1); eq.push_back(E(0, 1, 0, 0, 0, 0));
    if (FWD) begin
      sq.push_back(ADD_R4); eq.push_back(E(0, 1, 1, 0, 'h2, 0));
      sq.push_back(IDLE);   eq.push_back(E(0, 0, 0, 0, 'h12, 0));
      sq.push_back(IDLE);   eq.push_back(E(0, 0, 0, 0, 'h12, 0));
      sq.push_back(IDLE);   eq.push_back(E(0, 0, 0, 0, 'h10, 0));
    end else begin
      sq.push_back(ADD_R4); eq.push_back(E(1, 0, 0, 0, 'h2, 0));
      sq.push_back(ADD_R4); eq.push_back(E(1, 0, 0, 0, 'h2, 0));
      sq.push_back(ADD_R4); eq.push_back(E(0, 1, 0, 0, 'h2, 0));
      for (int k = 0; k < 3; k++) begin
        sq.push_back(IDLE); eq.push_back(E(0, 0, 0, 0, 'h10, 0));
      end
    end
    sq.push_back(IDLE); eq.push_back(E(0, 0, 0, 0, 0, 0));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(posedge clk1); #1; apply(s);
      @(negedge clk1);
      e = eq.pop_front();
      got = {stall, issue, fwd_a, fwd_b, busy, halted};
      total++;
      if (got !== e) begin bad++; $display("FAIL raw_alu row%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_load_use();
    stim_t s; exp_t got, e; int n = 0;
    sq.push_back(LW_R5);  eq.push_back(E(0, 1, 0, 0, 0, 0));
    sq.push_back(ADD_R6); eq.push_back(E(1, 0, 0, 0, 'h20, 0));
    if (FWD) begin
      sq.push_back(ADD_R6); eq.push_back(E(0, 1, 2, 0, 'h20, 0));
      sq.push_back(IDLE);   eq.push_back(E(0, 0, 0, 0, 'h60, 0));
      sq.push_back(IDLE);   eq.push_back(E(0, 0, 0, 0, 'h40, 0));
      sq.push_back(IDLE);   eq.push_back(E(0, 0, 0, 0, 'h40, 0));
    end else begin
      sq.push_back(ADD_R6); eq.push_back(E(1, 0, 0, 0, 'h20, 0));
      sq.push_back(ADD_R6); eq.push_back(E(0, 1, 0, 0, 'h20, 0));
      for (int k = 0; k < 3; k++) begin
        sq.push_back(IDLE); eq.push_back(E(0, 0, 0, 0, 'h40, 0));
      end
    end
    sq.push_back(IDLE); eq.push_back(E(0, 0, 0, 0, 0, 0));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(posedge clk1); #1; apply(s);
      @(negedge clk1);
      e = eq.pop_front();
      got = {stall, issue, fwd_a, fwd_b, busy, halted};
      total++;
      if (got !== e) begin bad++; $display("FAIL load_use row%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_r0();
    stim_t s; exp_t got, e; int n = 0;
    sq.push_back(ADDI_R0); eq.push_back(E(0, 1, 0, 0, 0, 0));
    sq.push_back(ADD_R7);  eq.push_back(E(0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      sq.push_back(IDLE); eq.push_back(E(0, 0, 0, 0, 'h80, 0));
    end
    sq.push_back(IDLE); eq.push_back(E(0, 0, 0, 0, 0, 0));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(posedge clk1); #1; apply(s);
      @(negedge clk1);
      e = eq.pop_front();
      got = {stall, issue, fwd_a, fwd_b, busy, halted};
      total++;
      if (got !== e) begin bad++; $display("FAIL r0 row%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_flush();
    stim_t s; exp_t got, e; int n = 0;
    sq.push_back(LW_R1);     eq.push_back(E(0, 1, 0, 0, 0, 0));
    sq.push_back(ADD_R4);    eq.push_back(E(1, 0, 0, 0, 'h2, 0));
    sq.push_back(ADD_R4_FL); eq.push_back(E(0, 0, FWD ? 2 : 0, 0, 'h2, 0));
    sq.push_back(IDLE);      eq.push_back(E(0, 0, 0, 0, 'h2, 0));
    sq.push_back(IDLE);      eq.push_back(E(0, 0, 0, 0, 0, 0));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(posedge clk1); #1; apply(s);
      @(negedge clk1);
      e = eq.pop_front();
      got = {stall, issue, fwd_a, fwd_b, busy, halted};
      total++;
      if (got !== e) begin bad++; $display("FAIL flush row%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_halt();
    stim_t s; exp_t got, e; int n = 0;
    sq.push_back(ADDI_R9); eq.push_back(E(0, 1, 0, 0, 0, 0));
    sq.push_back(HLT);     eq.push_back(E(0, 1, 0, 0, 'h200, 0));
    sq.push_back(ADD_R10); eq.push_back(E(0, 0, 0, 0, 'h200, 1));
    sq.push_back(ADD_R10); eq.push_back(E(0, 0, 0, 0, 'h200, 1));
    sq.push_back(ADD_R10); eq.push_back(E(0, 0, 0, 0, 0, 1));
    sq.push_back(IDLE);    eq.push_back(E(0, 0, 0, 0, 0, 1));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(posedge clk1); #1; apply(s);
      @(negedge clk1);
      e = eq.pop_front();
      got = {stall, issue, fwd_a, fwd_b, busy, halted};
      total++;
      if (got !== e) begin bad++; $display("FAIL halt row%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s; exp_t got, e; int n = 0;
    // Clear the sticky halt left by the previous scenario.
    @(posedge clk1); #1;
    rst_n = 1'b0;
    apply(ADD_R4);
    eq.push_back(E(0, 0, 0, 0, 0, 0));
    @(negedge clk1);
    e = eq.pop_front();
    got = {stall, issue, fwd_a, fwd_b, busy, halted};
    total++;
    if (got !== e) begin bad++; $display("FAIL halt_cleared got=%h exp=%h", got, e); end
    @(posedge clk1); #1;
    rst_n = 1'b1;
    apply(IDLE);
    sq.push_back(LW_R1);  eq.push_back(E(0, 1, 0, 0, 0, 0));
    sq.push_back(ADD_R4); eq.push_back(E(1, 0, 0, 0, 'h2, 0));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(posedge clk1); #1; apply(s);
      @(negedge clk1);
      e = eq.pop_front();
      got = {stall, issue, fwd_a, fwd_b, busy, halted};
      total++;
      if (got !== e) begin bad++; $display("FAIL mid_stall row%0d got=%h exp=%h", n, got, e); end
      n++;
    end
    // Reset dropped between clock edges while the ADD is still stalled.
    #2 rst_n = 1'b0;
    eq.push_back(E(0, 0, 0, 0, 0, 0));
    #1;
    e = eq.pop_front();
    got = {stall, issue, fwd_a, fwd_b, busy, halted};
    total++;
    if (got !== e) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, e); end
    @(posedge clk1); #1;
    rst_n = 1'b1;
    apply(IDLE);
    eq.push_back(E(0, 0, 0, 0, 0, 0));
    @(negedge clk1);
    e = eq.pop_front();
    got = {stall, issue, fwd_a, fwd_b, busy, halted};
    total++;
    if (got !== e) begin bad++; $display("FAIL post_reset got=%h exp=%h", got, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raw_alu();
    test_load_use();
    test_r0();
    test_flush();
    test_halt();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
